// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// overflow_o exists only when ADDER_OVERFLOW_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
`ifdef ADDER_OVERFLOW_EN
  logic             overflow_o;
`endif

  modport slave (
    input  valid_i, a_i, b_i, carry_i, ready_i,
    output ready_o, valid_o, sum_o, carry_o
`ifdef ADDER_OVERFLOW_EN
    , output overflow_o
`endif
  );

  modport master (
    output valid_i, a_i, b_i, carry_i, ready_i,
    input  ready_o, valid_o, sum_o, carry_o
`ifdef ADDER_OVERFLOW_EN
    , input overflow_o
`endif
  );
endinterface

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: stage k adds slice k, upper operands skewed, lower sums deskewed.
// Define ADDER_OVERFLOW_EN to add the registered signed-overflow output overflow_o.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  pipelined_adder_if.slave bus
);
  localparam int N     = (STAGES < 1) ? 1 : STAGES;
  localparam int SLICE = WIDTH / N;
  localparam int LAST  = N - 1;

  if (STAGES < 1 || (WIDTH % N) != 0) begin : g_bad_params
    $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH");
  end

  function automatic logic [SLICE:0] add_slice(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  endfunction

  logic [WIDTH-1:0] a_p [N];
  logic [WIDTH-1:0] b_p [N];
  logic [WIDTH-1:0] s_p [N];
  logic             c_p [N];
  logic [N-1:0]     vld_p;
`ifdef ADDER_OVERFLOW_EN
  logic             ov_p;
`endif

  logic [WIDTH-1:0] a_in  [N];
  logic [WIDTH-1:0] b_in  [N];
  logic [WIDTH-1:0] s_in  [N];
  logic [WIDTH-1:0] s_nxt [N];
  logic             c_in  [N];
  logic             c_nxt [N];
  logic [N-1:0]     vld_in;
  logic [N-1:0]     en;

  // Stage inputs: stage 0 from the bus, stage k from the register of stage k-1.
  always_comb begin
    a_in[0]   = bus.a_i;
    b_in[0]   = bus.b_i;
    s_in[0]   = '0;
    c_in[0]   = bus.carry_i;
    vld_in[0] = bus.valid_i;
    for (int k = 1; k < N; k++) begin
      a_in[k]   = a_p[k-1];
      b_in[k]   = b_p[k-1];
      s_in[k]   = s_p[k-1];
      c_in[k]   = c_p[k-1];
      vld_in[k] = vld_p[k-1];
    end
    for (int k = 0; k < N; k++) begin
      s_nxt[k] = s_in[k];
      {c_nxt[k], s_nxt[k][k*SLICE +: SLICE]} =
        add_slice(a_in[k][k*SLICE +: SLICE], b_in[k][k*SLICE +: SLICE], c_in[k]);
    end
  end

  // A stage may load when it, or any stage after it, is empty, or when the output drains.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      en[k] = bus.ready_i || !(&(vld_p | ((N'(1) << k) - N'(1))));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (en[k]) vld_p[k] <= vld_in[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N; k++) begin
      if (en[k] && vld_in[k]) begin
        a_p[k] <= a_in[k];
        b_p[k] <= b_in[k];
        s_p[k] <= s_nxt[k];
        c_p[k] <= c_nxt[k];
      end
    end
`ifdef ADDER_OVERFLOW_EN
    // Carry into the MSB is recovered as a^b^sum at bit WIDTH-1.
    if (en[LAST] && vld_in[LAST]) begin
      ov_p <= a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1] ^ s_nxt[LAST][WIDTH-1] ^ c_nxt[LAST];
    end
`endif
  end

  // Output stage: results read as zero whenever no transaction is held.
  assign bus.valid_o = vld_p[LAST];
  assign bus.ready_o = rstn_i && en[0];
  assign bus.sum_o   = vld_p[LAST] ? s_p[LAST] : '0;
  assign bus.carry_o = vld_p[LAST] && c_p[LAST];
`ifdef ADDER_OVERFLOW_EN
  assign bus.overflow_o = vld_p[LAST] && ov_p;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (32/4 main instance, 8/1 degenerate instance).
module tb_pipelined_adder;
  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ov;
    int           t;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W)) bus ();
  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));
  pipelined_adder_if #(.WIDTH(8)) bus8 ();
  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (.clk_i(clk), .rstn_i(rstn), .bus(bus8));

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc   = 0;
  bit           lat_chk = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_c;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int t);
    exp_t            e;
    longint unsigned full;
    full  = longint'(a) + longint'(b) + (cin ? 64'd1 : 64'd0);
    e.sum = full[W-1:0];
    e.c   = full[W];
    e.ov  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.t   = t;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bus.valid_i = v;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.carry_i = c;
  endtask

  // One clock: scoreboard at the falling edge, then advance to just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      check("stall_valid", 64'(bus.valid_o), 64'd1);
      check("stall_sum", 64'(bus.sum_o), 64'(prev_sum));
      check("stall_carry", 64'(bus.carry_o), 64'(prev_c));
    end
    if (bus.valid_o && bus.ready_i) begin
      if (q.size() == 0) begin
        check("spurious_result", 64'(bus.valid_o), 64'd0);
      end else begin
        e = q.pop_front();
        check("sum", 64'(bus.sum_o), 64'(e.sum));
        check("carry", 64'(bus.carry_o), 64'(e.c));
`ifdef ADDER_OVERFLOW_EN
        check("overflow", 64'(bus.overflow_o), 64'(e.ov));
`endif
        if (lat_chk) check("latency", 64'(cyc - e.t), 64'(S));
      end
    end
    if (bus.valid_i && bus.ready_o) q.push_back(model(bus.a_i, bus.b_i, bus.carry_i, cyc));
    prev_stall = bus.valid_o && !bus.ready_i;
    prev_sum   = bus.sum_o;
    prev_c     = bus.carry_o;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain();
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4 * S + 8 && q.size() > 0; i++) step();
    check("drain_remaining", 64'(q.size()), 64'd0);
  endtask

  // Sends one transaction into an empty pipeline and checks it arrives after S cycles.
  task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] xs, input logic xc, input string tag);
    bus.ready_i = 1'b1;
    drive(1'b1, a, b, cin);
    step();
    bus.valid_i = 1'b0;
    for (int i = 1; i < S; i++) begin
      check({tag, "_early"}, 64'(bus.valid_o), 64'd0);
      step();
    end
    check({tag, "_valid"}, 64'(bus.valid_o), 64'd1);
    check({tag, "_sum"}, 64'(bus.sum_o), 64'(xs));
    check({tag, "_carry"}, 64'(bus.carry_o), 64'(xc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int           acc;
    int           seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [8:0]   r8;
    logic [7:0]   a8;
    logic [7:0]   b8;
    logic         c8;

    drive(1'b0, '0, '0, 1'b0);
    bus.ready_i  = 1'b0;
    bus8.valid_i = 1'b0;
    bus8.a_i     = '0;
    bus8.b_i     = '0;
    bus8.carry_i = 1'b0;
    bus8.ready_i = 1'b1;

    #1 rstn = 1'b0;
    #2;
    check("rst_valid", 64'(bus.valid_o), 64'd0);
    check("rst_sum", 64'(bus.sum_o), 64'd0);
    check("rst_carry", 64'(bus.carry_o), 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst8_valid", 64'(bus8.valid_o), 64'd0);
`ifdef ADDER_OVERFLOW_EN
    check("rst_overflow", 64'(bus.overflow_o), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1 check("release_ready", 64'(bus.ready_o), 64'd1);

    // Wrap around the full width.
    lat_chk = 1'b1;
    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "wrap");
    step();

    // Back-to-back stream a=i, b=10*i.
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, W'(i), W'(10 * i), 1'b0);
      step();
    end
    drain();

    // Backpressure: continuous input while the output is blocked.
    lat_chk = 1'b0;
    bus.ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom));
      if (bus.ready_o) acc++;
      step();
    end
    check("bp_accepted", 64'(acc), 64'(S));
    check("bp_ready_low", 64'(bus.ready_o), 64'd0);
    bus.ready_i = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.ready_o), 64'd1);
    check("bp_release_valid", 64'(bus.valid_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom));
      step();
    end
    drain();

    // Random traffic with random backpressure and corner operands.
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
      drive(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom));
      bus.ready_i = 1'($urandom_range(0, 2) != 0);
      step();
    end
    drain();

`ifdef ADDER_OVERFLOW_EN
    lat_chk = 1'b1;
    single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, "ovf_pos");
    check("ovf_pos_flag", 64'(bus.overflow_o), 64'd1);
    step();
    single(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, "ovf_neg");
    check("ovf_neg_flag", 64'(bus.overflow_o), 64'd1);
    step();
    lat_chk = 1'b0;
`endif

    // Reset while three transactions are in flight.
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0);
      step();
    end
    bus.valid_i = 1'b0;
    step();
    check("pre_reset_valid", 64'(bus.valid_o), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.valid_o), 64'd0);
    check("midrst_sum", 64'(bus.sum_o), 64'd0);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    #1 check("midrst_release_ready", 64'(bus.ready_o), 64'd1);
    bus.ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.valid_o) seen++;
      step();
    end
    check("midrst_no_results", 64'(seen), 64'd0);

    // Degenerate single-stage instance.
    bus8.a_i     = 8'h0F;
    bus8.b_i     = 8'h00;
    bus8.carry_i = 1'b1;
    bus8.valid_i = 1'b1;
    check("deg_ready", 64'(bus8.ready_o), 64'd1);
    @(posedge clk);
    #1 bus8.valid_i = 1'b0;
    check("deg_valid", 64'(bus8.valid_o), 64'd1);
    check("deg_sum", 64'(bus8.sum_o), 64'h10);
    check("deg_carry", 64'(bus8.carry_o), 64'd0);
    for (int i = 0; i < 16; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      bus8.a_i     = a8;
      bus8.b_i     = b8;
      bus8.carry_i = c8;
      bus8.valid_i = 1'b1;
      @(posedge clk);
      #1;
      r8 = 9'(int'(a8) + int'(b8) + int'(c8));
      check("deg_rand_valid", 64'(bus8.valid_o), 64'd1);
      check("deg_rand_sum", 64'(bus8.sum_o), 64'(r8[7:0]));
      check("deg_rand_carry", 64'(bus8.carry_o), 64'(r8[8]));
    end
    bus8.valid_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
